// File: rtl/mips_writeback_unit.sv
// MIPS write-back stage: MEM/WB pipeline register, architectural HI/LO,
// big-endian sub-word load formatting and register-file write port.
module mips_writeback_unit #(
  parameter int data_width     = 32,
  parameter int reg_addr_width = 5,
  parameter int off_width      = $clog2(data_width / 8)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic                      in_reg_write,
  input  logic [reg_addr_width-1:0] in_dest_reg,
  input  logic [2:0]                in_reg_write_src,
  input  logic [data_width-1:0]     in_alu_data,
  input  logic [data_width-1:0]     in_mem_data,
  input  logic [data_width-1:0]     in_pc_plus4,
  input  logic [1:0]                in_load_size,
  input  logic                      in_load_signed,
  input  logic [off_width-1:0]      in_byte_off,
  input  logic [1:0]                hilo_we,
  input  logic [data_width-1:0]     hi_in,
  input  logic [data_width-1:0]     lo_in,
  output logic                      wb_valid,
  output logic                      wb_we,
  output logic [reg_addr_width-1:0] wb_addr,
  output logic [data_width-1:0]     wb_data,
  output logic [data_width-1:0]     hi_reg,
  output logic [data_width-1:0]     lo_reg
);

  localparam int n_bytes  = data_width / 8;
  localparam int n_halves = data_width / 16;

  logic                      valid_reg;
  logic                      reg_write_reg;
  logic [reg_addr_width-1:0] dest_reg;
  logic [2:0]                src_reg;
  logic [data_width-1:0]     alu_reg;
  logic [data_width-1:0]     mem_reg;
  logic [data_width-1:0]     pc4_reg;
  logic [1:0]                size_reg;
  logic                      signed_reg;
  logic [off_width-1:0]      off_reg;

  // Flush only kills the valid bit; the payload is don't-care in a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      dest_reg      <= '0;
      src_reg       <= '0;
      alu_reg       <= '0;
      mem_reg       <= '0;
      pc4_reg       <= '0;
      size_reg      <= '0;
      signed_reg    <= 1'b0;
      off_reg       <= '0;
    end else if (flush) begin
      valid_reg     <= 1'b0;
    end else if (!stall) begin
      valid_reg     <= in_valid;
      reg_write_reg <= in_reg_write;
      dest_reg      <= in_dest_reg;
      src_reg       <= in_reg_write_src;
      alu_reg       <= in_alu_data;
      mem_reg       <= in_mem_data;
      pc4_reg       <= in_pc_plus4;
      size_reg      <= in_load_size;
      signed_reg    <= in_load_signed;
      off_reg       <= in_byte_off;
    end
  end

  // HI/LO follow the mult/div unit's own handshake, not the pipeline controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      if (hilo_we[1]) hi_reg <= hi_in;
      if (hilo_we[0]) lo_reg <= lo_in;
    end
  end

  // Lane 0 is the most-significant byte/half (big-endian).
  logic [7:0]  byte_lane [n_bytes];
  logic [15:0] half_lane [n_halves];

  genvar gi;
  generate
    for (gi = 0; gi < n_bytes; gi++) begin : g_byte_lane
      assign byte_lane[gi] = mem_reg[data_width-1-8*gi -: 8];
    end
    for (gi = 0; gi < n_halves; gi++) begin : g_half_lane
      assign half_lane[gi] = mem_reg[data_width-1-16*gi -: 16];
    end
  endgenerate

  logic [off_width-2:0] half_idx;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [data_width-1:0] load_data;

  assign half_idx = off_reg[off_width-1:1];

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < n_bytes; i++) begin
      if (off_reg == off_width'(i)) byte_sel = byte_lane[i];
    end
    half_sel = '0;
    for (int i = 0; i < n_halves; i++) begin
      if (half_idx == (off_width-1)'(i)) half_sel = half_lane[i];
    end
  end

  always_comb begin
    load_data = mem_reg;
    case (size_reg)
      2'd1:    load_data = {{(data_width-16){signed_reg & half_sel[15]}}, half_sel};
      2'd2:    load_data = {{(data_width-8){signed_reg & byte_sel[7]}}, byte_sel};
      default: load_data = mem_reg;
    endcase
  end

  always_comb begin
    wb_data = alu_reg;
    case (src_reg)
      3'd0:    wb_data = alu_reg;
      3'd1:    wb_data = load_data;
      3'd2:    wb_data = hilo_we[1] ? hi_in : hi_reg;
      3'd3:    wb_data = hilo_we[0] ? lo_in : lo_reg;
      default: wb_data = pc4_reg;
    endcase
  end

  assign wb_valid = valid_reg;
  assign wb_addr  = dest_reg;
  assign wb_we    = valid_reg & reg_write_reg & (dest_reg != '0);

endmodule

// File: tb/tb_mips_writeback_unit.sv
// Directed self-checking bench for mips_writeback_unit: one task per feature,
// expected values hand-computed from the stage's documented behaviour.
module tb_mips_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        in_valid, in_reg_write;
  logic [4:0]  in_dest_reg;
  logic [2:0]  in_reg_write_src;
  logic [31:0] in_alu_data, in_mem_data, in_pc_plus4;
  logic [1:0]  in_load_size;
  logic        in_load_signed;
  logic [1:0]  in_byte_off;
  logic [1:0]  hilo_we;
  logic [31:0] hi_in, lo_in;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, hi_reg, lo_reg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_writeback_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_dest_reg(in_dest_reg),
    .in_reg_write_src(in_reg_write_src), .in_alu_data(in_alu_data),
    .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4),
    .in_load_size(in_load_size), .in_load_signed(in_load_signed),
    .in_byte_off(in_byte_off), .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .hi_reg(hi_reg), .lo_reg(lo_reg)
  );

  task automatic drive(input logic v, input logic rw, input logic [4:0] d,
                       input logic [2:0] s, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc,
                       input logic [1:0] sz, input logic sg, input logic [1:0] off);
    in_valid = v; in_reg_write = rw; in_dest_reg = d; in_reg_write_src = s;
    in_alu_data = alu; in_mem_data = mem; in_pc_plus4 = pc;
    in_load_size = sz; in_load_signed = sg; in_byte_off = off;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 5'd7, 3'd0, 32'h5555_AAAA, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    hilo_we = 2'b11; hi_in = 32'hFFFF_FFFF; lo_in = 32'hEEEE_EEEE;
    repeat (2) @(posedge clk);
    #1;
    $display("txn reset: valid=%0b we=%0b addr=%0d data=%h hi=%h lo=%h",
             wb_valid, wb_we, wb_addr, wb_data, hi_reg, lo_reg);
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", wb_valid); end
    n_cmp++; if (wb_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", wb_we); end
    n_cmp++; if (wb_addr !== 5'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", wb_addr); end
    n_cmp++; if (wb_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", wb_data); end
    n_cmp++; if (hi_reg !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi_reg); end
    n_cmp++; if (lo_reg !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo_reg); end
    @(negedge clk);
    rst_n = 1'b1; hilo_we = 2'b00;
  endtask

  task automatic test_alu;
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd8, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    @(posedge clk); #1;
    $display("txn alu: we=%0b addr=%0d data=%h", wb_we, wb_addr, wb_data);
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL alu_valid: got %b want 1", wb_valid); end
    n_cmp++; if (wb_we !== 1'b1) begin n_bad++; $display("FAIL alu_we: got %b want 1", wb_we); end
    n_cmp++; if (wb_addr !== 5'd8) begin n_bad++; $display("FAIL alu_addr: got %0d want 8", wb_addr); end
    n_cmp++; if (wb_data !== 32'h0000_1234) begin n_bad++; $display("FAIL alu_data: got %h want 00001234", wb_data); end
  endtask

  task automatic test_loads;
    logic [1:0]  sz  [7] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3};
    logic        sg  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  off [7] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
    logic [31:0] exp [7] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                             32'h0000_7F01, 32'h0000_0080, 32'h80FF_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd4, 3'd1, 32'h0, 32'h80FF_7F01, 32'h0, sz[i], sg[i], off[i]);
      @(posedge clk); #1;
      $display("txn load%0d: size=%0d signed=%0b off=%0d data=%h", i, sz[i], sg[i], off[i], wb_data);
      n_cmp++; if (wb_data !== exp[i]) begin n_bad++; $display("FAIL load%0d: got %h want %h", i, wb_data, exp[i]); end
    end
  endtask

  task automatic test_zero_dest;
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd0, 3'd0, 32'h0000_BEEF, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    @(posedge clk); #1;
    $display("txn zero_dest: valid=%0b we=%0b", wb_valid, wb_we);
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL zero_dest_valid: got %b want 1", wb_valid); end
    n_cmp++; if (wb_we !== 1'b0) begin n_bad++; $display("FAIL zero_dest_we: got %b want 0", wb_we); end
  endtask

  task automatic test_stall_flush;
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd9, 3'd0, 32'hAAAA_0001, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1;
      drive(1'b1, 1'b1, 5'(10 + i), 3'd0, 32'h1111_0000 + i, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
      @(posedge clk); #1;
      $display("txn stall%0d: we=%0b addr=%0d data=%h", i, wb_we, wb_addr, wb_data);
      n_cmp++; if (wb_addr !== 5'd9) begin n_bad++; $display("FAIL stall_addr%0d: got %0d want 9", i, wb_addr); end
      n_cmp++; if (wb_data !== 32'hAAAA_0001) begin n_bad++; $display("FAIL stall_data%0d: got %h want aaaa0001", i, wb_data); end
      n_cmp++; if (wb_we !== 1'b1) begin n_bad++; $display("FAIL stall_we%0d: got %b want 1", i, wb_we); end
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    $display("txn stall_flush: valid=%0b we=%0b", wb_valid, wb_we);
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", wb_valid); end
    n_cmp++; if (wb_we !== 1'b0) begin n_bad++; $display("FAIL flush_we: got %b want 0", wb_we); end
    @(negedge clk);
    flush = 1'b0; stall = 1'b0;
    drive(1'b1, 1'b1, 5'd20, 3'd0, 32'h0BAD_F00D, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    @(posedge clk); #1;
    $display("txn resume: addr=%0d data=%h", wb_addr, wb_data);
    n_cmp++; if (wb_addr !== 5'd20) begin n_bad++; $display("FAIL resume_addr: got %0d want 20", wb_addr); end
    @(negedge clk);
    stall = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    $display("txn reset_in_stall: valid=%0b addr=%0d", wb_valid, wb_addr);
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stall_valid: got %b want 0", wb_valid); end
    n_cmp++; if (wb_addr !== 5'd0) begin n_bad++; $display("FAIL rst_stall_addr: got %0d want 0", wb_addr); end
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
  endtask

  task automatic test_hilo;
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd3, 3'd2, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    hi_in = 32'h1111_1111; lo_in = 32'h2222_2222; hilo_we = 2'b00;
    @(posedge clk); #1;
    n_cmp++; if (wb_data !== 32'h0) begin n_bad++; $display("FAIL hi_nobypass: got %h want 0", wb_data); end
    hilo_we = 2'b10; hi_in = 32'hDEAD_0000;
    #1;
    $display("txn hi_bypass: data=%h hi=%h", wb_data, hi_reg);
    n_cmp++; if (wb_data !== 32'hDEAD_0000) begin n_bad++; $display("FAIL hi_bypass: got %h want dead0000", wb_data); end
    n_cmp++; if (hi_reg !== 32'h0) begin n_bad++; $display("FAIL hi_reg_early: got %h want 0", hi_reg); end
    @(posedge clk); #1;
    hilo_we = 2'b00; hi_in = 32'h1111_1111;
    #1;
    $display("txn hi_stored: data=%h hi=%h", wb_data, hi_reg);
    n_cmp++; if (hi_reg !== 32'hDEAD_0000) begin n_bad++; $display("FAIL hi_reg: got %h want dead0000", hi_reg); end
    n_cmp++; if (wb_data !== 32'hDEAD_0000) begin n_bad++; $display("FAIL hi_read: got %h want dead0000", wb_data); end
    n_cmp++; if (lo_reg !== 32'h0) begin n_bad++; $display("FAIL lo_untouched: got %h want 0", lo_reg); end
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd5, 3'd3, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    @(posedge clk); #1;
    stall = 1'b1; hilo_we = 2'b01; lo_in = 32'hCAFE_BABE;
    #1;
    n_cmp++; if (wb_data !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL lo_bypass: got %h want cafebabe", wb_data); end
    @(posedge clk); #1;
    $display("txn lo_in_stall: lo=%h valid=%0b addr=%0d", lo_reg, wb_valid, wb_addr);
    n_cmp++; if (lo_reg !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL lo_stall: got %h want cafebabe", lo_reg); end
    n_cmp++; if (hi_reg !== 32'hDEAD_0000) begin n_bad++; $display("FAIL hi_kept: got %h want dead0000", hi_reg); end
    hilo_we = 2'b11; hi_in = 32'h1234_5678; lo_in = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    hilo_we = 2'b00; stall = 1'b0;
    $display("txn hilo_both: hi=%h lo=%h", hi_reg, lo_reg);
    n_cmp++; if (hi_reg !== 32'h1234_5678) begin n_bad++; $display("FAIL both_hi: got %h want 12345678", hi_reg); end
    n_cmp++; if (lo_reg !== 32'h9ABC_DEF0) begin n_bad++; $display("FAIL both_lo: got %h want 9abcdef0", lo_reg); end
  endtask

  task automatic test_link;
    logic [2:0] srcs [3] = '{3'd4, 3'd7, 3'd5};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd31, srcs[i], 32'h0000_0BAD, 32'h0000_0BAD, 32'h0040_0008, 2'd0, 1'b0, 2'd0);
      @(posedge clk); #1;
      $display("txn link src=%0d: data=%h", srcs[i], wb_data);
      n_cmp++; if (wb_data !== 32'h0040_0008) begin n_bad++; $display("FAIL link_src%0d: got %h want 00400008", srcs[i], wb_data); end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 5'(i), 3'd0, 32'h100 * i, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
      @(posedge clk); #1;
      $display("txn b2b%0d: addr=%0d data=%h", i, wb_addr, wb_data);
      n_cmp++; if (wb_addr !== 5'(i) || wb_data !== 32'h100 * i) begin
        n_bad++; $display("FAIL b2b%0d: got %0d/%h want %0d/%h", i, wb_addr, wb_data, i, 32'h100 * i);
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd6, 3'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    @(posedge clk); #1;
    n_cmp++; if (wb_we !== 1'b0) begin n_bad++; $display("FAIL invalid_we: got %b want 0", wb_we); end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_loads;
    test_zero_dest;
    test_stall_flush;
    test_hilo;
    test_link;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
